// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the board reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CAUSE_POR  = 2'd0,
        CAUSE_LOCK = 2'd1,
        CAUSE_BTN  = 2'd2
    } cause_t;

    // Width of a counter that must hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for the reset button.
module button_debounce
    import reset_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             btn_meta;
    logic             btn_sync;
    logic [CNT_W-1:0] stable_cnt;

    // Level only flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            btn_meta   <= 1'b0;
            btn_sync   <= 1'b0;
            stable_cnt <= '0;
            level_o    <= 1'b0;
            press_o    <= 1'b0;
        end else begin
            btn_meta <= btn_i;
            btn_sync <= btn_meta;
            press_o  <= 1'b0;
            if (btn_sync == level_o) begin
                stable_cnt <= '0;
            end else if (stable_cnt >= CNT_MAX) begin
                level_o    <= btn_sync;
                press_o    <= btn_sync;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Lock-aware board reset controller: waits for PLL lock, holds, then releases
// reset domains in ascending order; re-enters reset on lock loss or button.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                NUM_OUTPUTS      = 2,
    parameter int                HOLD_CYCLES      = 31,
    parameter int                STAGE_GAP_CYCLES = 16,
    parameter int                DEBOUNCE_CYCLES  = 250000,
    parameter int                SEL_W            = 4,
    parameter logic [SEL_W-1:0]  BTN_CODE         = SEL_W'(1)
) (
    input  logic                   clk,
    input  logic                   reset_i,
    input  logic                   locked_i,
    input  logic                   btn_i,
    input  logic [SEL_W-1:0]       sel_i,
    output logic [NUM_OUTPUTS-1:0] reset_o,
    output logic                   ready_o,
    output logic [1:0]             cause_o
);

    localparam int HOLD_W  = cnt_width(HOLD_CYCLES - 1);
    localparam int GAP_W   = cnt_width(STAGE_GAP_CYCLES - 1);
    localparam int STAGE_W = cnt_width(NUM_OUTPUTS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]   GAP_MAX    = GAP_W'(STAGE_GAP_CYCLES - 1);
    localparam logic [STAGE_W-1:0] STAGE_LAST = STAGE_W'(NUM_OUTPUTS - 1);

    state_t             state;
    logic               lock_meta;
    logic               lock_sync;
    logic [HOLD_W-1:0]  hold_cnt;
    logic [GAP_W-1:0]   gap_cnt;
    logic [STAGE_W-1:0] stage;
    logic [STAGE_W-1:0] next_stage;
    logic               btn_level;
    logic               btn_press;
    logic               sel_match;

    assign sel_match  = (sel_i == BTN_CODE);
    assign next_stage = stage + 1'b1;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset_i (reset_i),
        .btn_i   (btn_i),
        .level_o (btn_level),
        .press_o (btn_press)
    );

    // Sequencer: lock loss outranks the button, both outrank normal progress.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            state     <= WAIT_LOCK;
            reset_o   <= '1;
            ready_o   <= 1'b0;
            cause_o   <= CAUSE_POR;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            stage     <= '0;
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= locked_i;
            lock_sync <= lock_meta;
            if ((state != WAIT_LOCK) && !lock_sync) begin
                state    <= WAIT_LOCK;
                reset_o  <= '1;
                ready_o  <= 1'b0;
                cause_o  <= CAUSE_LOCK;
                hold_cnt <= '0;
                gap_cnt  <= '0;
                stage    <= '0;
            end else if (((state == RELEASE) || (state == RUN)) && btn_press && sel_match) begin
                state    <= HOLD;
                reset_o  <= '1;
                ready_o  <= 1'b0;
                cause_o  <= CAUSE_BTN;
                hold_cnt <= '0;
                gap_cnt  <= '0;
                stage    <= '0;
            end else begin
                case (state)
                    WAIT_LOCK: begin
                        reset_o <= '1;
                        ready_o <= 1'b0;
                        if (lock_sync) begin
                            state    <= HOLD;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= '0;
                        end
                    end
                    HOLD: begin
                        reset_o <= '1;
                        ready_o <= 1'b0;
                        if (btn_level && sel_match) begin
                            hold_cnt <= '0;
                        end else if (hold_cnt >= HOLD_MAX) begin
                            state      <= (NUM_OUTPUTS == 1) ? RUN : RELEASE;
                            ready_o    <= (NUM_OUTPUTS == 1);
                            reset_o[0] <= 1'b0;
                            stage      <= '0;
                            gap_cnt    <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    RELEASE: begin
                        if (gap_cnt >= GAP_MAX) begin
                            gap_cnt             <= '0;
                            stage               <= next_stage;
                            reset_o[next_stage] <= 1'b0;
                            if (next_stage == STAGE_LAST) begin
                                state   <= RUN;
                                ready_o <= 1'b1;
                            end else begin
                                ready_o <= 1'b0;
                            end
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        ready_o <= 1'b1;
                    end
                    default: begin
                        state   <= WAIT_LOCK;
                        reset_o <= '1;
                        ready_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed-vector bench for reset_sequencer with hand-computed edge timing.
module tb_reset_sequencer;

    logic       clk;
    logic       reset_i;
    logic       locked_i;
    logic       btn_i;
    logic [3:0] sel_i;
    logic [2:0] reset_o;
    logic       ready_o;
    logic [1:0] cause_o;

    int vectors     = 0;
    int miscompares = 0;

    reset_sequencer #(
        .NUM_OUTPUTS      (3),
        .HOLD_CYCLES      (8),
        .STAGE_GAP_CYCLES (4),
        .DEBOUNCE_CYCLES  (5),
        .SEL_W            (4),
        .BTN_CODE         (4'd1)
    ) dut (
        .clk      (clk),
        .reset_i  (reset_i),
        .locked_i (locked_i),
        .btn_i    (btn_i),
        .sel_i    (sel_i),
        .reset_o  (reset_o),
        .ready_o  (ready_o),
        .cause_o  (cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance n rising edges; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Release sequence measured from the edge after which the trigger (reset_i fall or lock rise) was driven.
    task automatic release_seq(input string tag, input logic [1:0] exp_cause);
        step(10);
        check_value({tag, " +10 rst"}, 32'(reset_o), 32'h7);
        check_value({tag, " +10 rdy"}, 32'(ready_o), 32'h0);
        step(1);
        check_value({tag, " +11 rst"}, 32'(reset_o), 32'h6);
        check_value({tag, " +11 cause"}, 32'(cause_o), 32'(exp_cause));
        step(3);
        check_value({tag, " +14 rst"}, 32'(reset_o), 32'h6);
        step(1);
        check_value({tag, " +15 rst"}, 32'(reset_o), 32'h4);
        step(3);
        check_value({tag, " +18 rst"}, 32'(reset_o), 32'h4);
        check_value({tag, " +18 rdy"}, 32'(ready_o), 32'h0);
        step(1);
        check_value({tag, " +19 rst"}, 32'(reset_o), 32'h0);
        check_value({tag, " +19 rdy"}, 32'(ready_o), 32'h1);
        check_value({tag, " +19 cause"}, 32'(cause_o), 32'(exp_cause));
    endtask

    initial begin
        reset_i  = 1'b1;
        locked_i = 1'b1;
        btn_i    = 1'b0;
        sel_i    = 4'd1;
        step(3);
        check_value("por rst", 32'(reset_o), 32'h7);
        check_value("por rdy", 32'(ready_o), 32'h0);
        check_value("por cause", 32'(cause_o), 32'h0);

        // Power-up with lock already present.
        reset_i = 1'b0;
        release_seq("powerup", 2'd0);

        // Late lock: nothing may release before lock + 11 edges.
        reset_i  = 1'b1;
        locked_i = 1'b0;
        step(2);
        reset_i = 1'b0;
        step(20);
        check_value("latelock wait rst", 32'(reset_o), 32'h7);
        locked_i = 1'b1;
        release_seq("latelock", 2'd0);

        // Lock loss in RUN.
        step(2);
        locked_i = 1'b0;
        step(2);
        check_value("lockloss +2 rst", 32'(reset_o), 32'h0);
        step(1);
        check_value("lockloss +3 rst", 32'(reset_o), 32'h7);
        check_value("lockloss +3 rdy", 32'(ready_o), 32'h0);
        check_value("lockloss +3 cause", 32'(cause_o), 32'h1);
        step(5);
        locked_i = 1'b1;
        release_seq("relock", 2'd1);

        // 3-cycle glitch with matching selector is filtered.
        step(2);
        btn_i = 1'b1;
        step(3);
        btn_i = 1'b0;
        step(12);
        check_value("glitch rst", 32'(reset_o), 32'h0);
        check_value("glitch cause", 32'(cause_o), 32'h1);

        // 6-cycle press: reset at +8, release 15 edges after button falls.
        btn_i = 1'b1;
        step(6);
        btn_i = 1'b0;
        step(1);
        check_value("btn +7 rst", 32'(reset_o), 32'h0);
        step(1);
        check_value("btn +8 rst", 32'(reset_o), 32'h7);
        check_value("btn +8 rdy", 32'(ready_o), 32'h0);
        check_value("btn +8 cause", 32'(cause_o), 32'h2);
        step(12);
        check_value("btnrel +14 rst", 32'(reset_o), 32'h7);
        step(1);
        check_value("btnrel +15 rst", 32'(reset_o), 32'h6);
        check_value("btnrel +15 cause", 32'(cause_o), 32'h2);

        // reset_i pulse while mid-release.
        reset_i = 1'b1;
        step(1);
        check_value("midrel rst", 32'(reset_o), 32'h7);
        check_value("midrel rdy", 32'(ready_o), 32'h0);
        check_value("midrel cause", 32'(cause_o), 32'h0);
        reset_i = 1'b0;
        release_seq("after midrel", 2'd0);

        // Non-matching selector: long press is ignored.
        sel_i = 4'd2;
        btn_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check_value("sel2 press rst", 32'(reset_o), 32'h0);
            check_value("sel2 press cause", 32'(cause_o), 32'h0);
        end
        btn_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check_value("sel2 idle rst", 32'(reset_o), 32'h0);
        end
        sel_i = 4'd1;

        // Lock loss and button event land on the same edge: lock wins.
        btn_i = 1'b1;
        step(5);
        locked_i = 1'b0;
        step(1);
        btn_i = 1'b0;
        step(1);
        check_value("simul +7 rst", 32'(reset_o), 32'h0);
        step(1);
        check_value("simul +8 rst", 32'(reset_o), 32'h7);
        check_value("simul +8 rdy", 32'(ready_o), 32'h0);
        check_value("simul +8 cause", 32'(cause_o), 32'h1);
        step(10);
        check_value("simul wait rst", 32'(reset_o), 32'h7);
        locked_i = 1'b1;
        release_seq("simul relock", 2'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
